// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types, instruction sizes and target alignment helper
package pipeline_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam logic [2:0] INSN_SIZE_FULL = 3'd4;
  localparam logic [2:0] INSN_SIZE_COMP = 3'd2;

  // Low address bits that must be cleared on any target; also used by the EX target adder.
  function automatic logic [1:0] align_low_mask(input logic c_ext);
    return c_ext ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next fetch PC priority mux with target alignment
module pc_next_sel
  import pipeline_pkg::*;
#(
  parameter int PC_WIDTH = 64,
  parameter int C_EXT    = 0
) (
  input  pc_state_t           state,
  input  logic                fire,
  input  logic                trap_redirect,
  input  logic [PC_WIDTH-1:0] trap_target,
  input  logic                br_redirect,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                halt,
  input  logic                pred_taken,
  input  logic [PC_WIDTH-1:0] pred_target,
  input  logic                inc_size,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                redirect,
  output logic                go_halt
);

  logic [PC_WIDTH-1:0] mask;
  logic [PC_WIDTH-1:0] inc;

  assign mask = ~{{(PC_WIDTH-2){1'b0}}, align_low_mask(C_EXT != 0)};
  assign inc  = ((C_EXT != 0) && inc_size) ? PC_WIDTH'(INSN_SIZE_COMP)
                                           : PC_WIDTH'(INSN_SIZE_FULL);

  // Redirects win over everything, including stall and an unaccepted request.
  always_comb begin
    redirect = trap_redirect | br_redirect;
    go_halt  = 1'b0;
    next_pc  = fetch_pc;
    if (trap_redirect)
      next_pc = trap_target & mask;
    else if (br_redirect)
      next_pc = br_target & mask;
    else if (state == RUN && halt)
      go_halt = 1'b1;
    else if (fire && pred_taken)
      next_pc = pred_target & mask;
    else if (fire)
      next_pc = fetch_pc + inc;
  end

endmodule

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - fetch PC generator: BOOT/RUN/HALT FSM, fetch request and accepted-fetch counter
module pc_gen_unit
  import pipeline_pkg::*;
#(
  parameter int                  PC_WIDTH     = 64,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  C_EXT        = 0,
  parameter int                  CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 trap_redirect,
  input  logic [PC_WIDTH-1:0]  trap_target,
  input  logic                 br_redirect,
  input  logic [PC_WIDTH-1:0]  br_target,
  input  logic                 pred_taken,
  input  logic [PC_WIDTH-1:0]  pred_target,
  input  logic                 inc_size,
  input  logic                 halt,
  input  logic                 fetch_req_ready,
  output logic                 fetch_req_valid,
  output logic [PC_WIDTH-1:0]  fetch_pc,
  output logic                 fetch_kill,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  pc_state_t           state, state_next;
  logic                fire, redirect, go_halt;
  logic [PC_WIDTH-1:0] next_pc;

  assign fetch_req_valid = (state == RUN);
  assign halted          = (state == HALT);
  assign fire            = fetch_req_valid & fetch_req_ready & ~stall;

  pc_next_sel #(
    .PC_WIDTH(PC_WIDTH),
    .C_EXT   (C_EXT)
  ) u_next_sel (
    .state        (state),
    .fire         (fire),
    .trap_redirect(trap_redirect),
    .trap_target  (trap_target),
    .br_redirect  (br_redirect),
    .br_target    (br_target),
    .halt         (halt),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .inc_size     (inc_size),
    .fetch_pc     (fetch_pc),
    .next_pc      (next_pc),
    .redirect     (redirect),
    .go_halt      (go_halt)
  );

  always_comb begin
    state_next = state;
    if (redirect)
      state_next = RUN;
    else begin
      case (state)
        BOOT:    state_next = RUN;
        RUN:     if (go_halt) state_next = HALT;
        default: state_next = state;
      endcase
    end
  end

  // A fire coinciding with a redirect is killed, so it is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_VECTOR;
      fetch_kill  <= 1'b0;
      fetch_count <= '0;
    end else begin
      state      <= state_next;
      fetch_pc   <= next_pc;
      fetch_kill <= redirect;
      if (fire && !redirect)
        fetch_count <= fetch_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Next-generation fetch PC generator for the five-stage pipeline.
- Replaces the plain stall/flush PC register with a parametrised unit. It owns the fetch PC, drives a valid/ready request to instruction memory, and arbitrates trap, branch and predictor redirects.
- Supports an optional compressed-instruction (+2) increment, a halt/WFI state and an accepted-fetch counter.
- Sits between the hazard/EX/CSR logic and the IF stage.

Parameters:
- PC_WIDTH, 64, width of all PC and target buses.
- RESET_VECTOR, 0, fetch_pc value loaded on reset.
- C_EXT, 0, 1 enables +2 increments and 2-byte target alignment; 0 forces +4 increments and 4-byte alignment.
- CNT_WIDTH, 32, width of fetch_count.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- stall  input  1  hazard-unit hold; blocks sequential and predicted advance only.
- trap_redirect  input  1  trap/mret redirect from CSR/MEM; highest priority.
- trap_target  input  PC_WIDTH  trap destination.
- br_redirect  input  1  mispredict/branch flush from EX.
- br_target  input  PC_WIDTH  resolved branch destination.
- pred_taken  input  1  predictor says the current fetch_pc is a taken branch.
- pred_target  input  PC_WIDTH  predicted destination.
- inc_size  input  1  0: +4, 1: +2. Ignored when C_EXT=0.
- halt  input  1  WFI/halt request from decode.
- fetch_req_ready  input  1  instruction memory accepts the request.
- fetch_req_valid  output  1  request valid.
- fetch_pc  output  PC_WIDTH  current fetch address.
- fetch_kill  output  1  one-cycle pulse: drop any in-flight fetch response.
- halted  output  1  unit is in HALT.
- fetch_count  output  CNT_WIDTH  number of accepted fetches.

Behaviour:
- States: BOOT, RUN, HALT.
- Reset (asynchronous, immediate, also mid-operation):
  - state=BOOT, fetch_pc=RESET_VECTOR.
  - fetch_req_valid=0, fetch_kill=0, halted=0, fetch_count=0.
- BOOT: lasts exactly one cycle after rst deasserts, then RUN. Redirects arriving in BOOT are applied and also move to RUN.
- RUN: fetch_req_valid=1.
- HALT: fetch_req_valid=0, halted=1. Only trap_redirect or br_redirect leaves HALT (to RUN). stall, halt and pred are ignored in HALT.
- Accept condition: fire = fetch_req_valid & fetch_req_ready & ~stall.
- Next-PC priority, evaluated every cycle, registered on the clk edge:
  1. trap_redirect -> trap_target.
  2. br_redirect -> br_target.
  3. halt (RUN only) -> HALT. fetch_pc holds. A fire in the same cycle is still counted.
  4. fire & pred_taken -> pred_target.
  5. fire -> fetch_pc + inc (inc=2 if C_EXT & inc_size, else 4).
  6. Otherwise hold.
- Redirect override rules:
  - Redirects (1, 2) override stall and an unaccepted request; fetch_pc may change while valid & ~ready.
  - fetch_kill is asserted in the cycle after any applied redirect, for exactly one cycle.
- Alignment: all targets have low bits zeroed before loading: bit 0 if C_EXT=1, bits [1:0] otherwise.
- Arithmetic: increment wraps modulo 2^PC_WIDTH; no overflow flag.
- Valid stability: without a redirect, fetch_pc and fetch_req_valid stay stable while valid & ~ready.
- fetch_count:
  - Increments on each fire, wraps at 2^CNT_WIDTH.
  - A fire in the same cycle as a redirect is not counted; the request is killed.
- Simultaneous trap and branch redirect: trap wins; br_target is discarded.

Decomposition:
- Shared package pipeline_pkg gets:
  - the state enum pc_state_t {BOOT, RUN, HALT};
  - constants for instruction sizes (4, 2);
  - an alignment-mask function shared with the EX target adder.
- One natural sub-module, pc_next_sel: the purely combinational priority mux plus alignment. The FSM, registers and counter stay in pc_gen_unit.

Test Plan:
- Reset, RESET_VECTOR=0x1000, ready=1, no stall -> valid=0 for one cycle. Then fetch_pc 0x1000, 0x1004, 0x1008. fetch_count=3 after three fires.
- C_EXT=1, inc_size=1 at 0x2000, then pred_taken with pred_target=0x3001 -> fetch_pc 0x2002, then 0x3000 (aligned). Repeat with C_EXT=0 -> 0x2004, then 0x3000 (0x3001 & ~3).
- stall=1 with br_redirect=1, br_target=0x4000 -> fetch_pc=0x4000 next cycle despite stall. fetch_kill=1 for one cycle. fetch_count unchanged.
- trap_redirect (0x8000) and br_redirect (0x4000) in the same cycle -> fetch_pc=0x8000. Then ready=0 for 3 cycles -> fetch_pc and valid stable at 0x8000.
- halt=1 in RUN -> halted=1, valid=0. pred_taken and stall toggling have no effect. trap_redirect to 0x100 -> RUN, fetch_pc=0x100, fetch_kill pulse.
- PC_WIDTH=64 at 0xFFFF_FFFF_FFFF_FFFC with fire -> fetch_pc wraps to 0x0. Assert rst mid-stall -> fetch_pc=RESET_VECTOR immediately, without waiting for a clk edge.
